rs_latch_monitor: RTL and testbench
===================================

RS_LATCH_MONITOR -- requirements
Module: rs_latch_monitor

Interface
REQ-001 The module SHALL have the parameter SETTLE_CYCLES, default 4: number of Clock cycles after an input change before Q is compared (legal range 1..255).
REQ-002 The module SHALL have the parameter CNT_W, default 16: width of the error and check counters.
REQ-003 The module SHALL have the port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have the port notR, input, 1 bit: active-low reset input of the latch under observation; asynchronous.
REQ-006 The module SHALL have the port notS, input, 1 bit: active-low set input of the latch under observation; asynchronous.
REQ-007 The module SHALL have the port Q, input, 1 bit: output of the latch under observation; asynchronous.
REQ-008 The module SHALL have the port expected_q, output, 1 bit: model value of Q.
REQ-009 The module SHALL have the port exp_valid, output, 1 bit: expected_q is defined.
REQ-010 The module SHALL have the port err_pulse, output, 1 bit: one-cycle pulse on each mismatch.
REQ-011 The module SHALL have the port illegal_pulse, output, 1 bit: one-cycle pulse on entry to notR=notS=0.
REQ-012 The module SHALL have the port error_count, output, CNT_W bits: mismatches counted, saturating.
REQ-013 The module SHALL have the port check_count, output, CNT_W bits: comparisons performed, saturating.
REQ-014 The module SHALL have the port pass, output, 1 bit: high when check_count!=0 and error_count==0.
REQ-015 The module SHALL have the port first_fail_time, output, 32 bits: free-running cycle stamp of the first mismatch (see Configuration).

Function
REQ-016 notR, notS and Q SHALL each pass through a 2-flop synchronizer; all logic uses only the synchronized versions (2-cycle input latency).
REQ-017 The model SHALL behave as follows: notR=0,notS=1 -> expected 0; notR=1,notS=0 -> expected 1; both 1 -> hold; both 0 -> illegal, exp_valid=0.
REQ-018 The FSM SHALL have the states UNKNOWN, SETTLE, CHECK and ILLEGAL.
REQ-019 In UNKNOWN, exp_valid SHALL be 0 and no comparisons made; a legal set or reset code SHALL go to SETTLE; hold stays in UNKNOWN; both 0 goes to ILLEGAL.
REQ-020 On any change of the synchronized notR/notS pair, SETTLE SHALL be entered and the settle counter loaded with SETTLE_CYCLES, whatever the current state.
REQ-021 In SETTLE, the settle counter SHALL decrement each cycle; on reaching 0 the FSM goes to CHECK, unless the inputs change again, which reloads it.
REQ-022 In CHECK, exactly one comparison SHALL be made in the entry cycle: check_count+1, and on Q!=expected_q error_count+1 and err_pulse=1; the FSM then remains idle in CHECK until the next input change.
REQ-023 In ILLEGAL, illegal_pulse SHALL fire once on entry, with no comparison and exp_valid=0; leaving to a legal code goes to SETTLE, and a following hold returns to UNKNOWN.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 A mismatch on the same cycle as an input change SHALL be discarded: the change wins and SETTLE is entered.

Reset
REQ-026 While nReset=0 the FSM SHALL be in UNKNOWN, synchronizers and counters 0, expected_q=0, exp_valid=0, pulses 0, pass=0 and first_fail_time=0.
REQ-027 Reset asserted mid-SETTLE or mid-CHECK SHALL abort immediately with no comparison counted.
REQ-028 After release, the first comparison SHALL occur no earlier than 2+SETTLE_CYCLES+1 cycles after a legal code appears.

Configuration
REQ-029 With RS_MON_FIRST_FAIL_EN defined, a 32-bit free-running cycle counter SHALL exist, and first_fail_time captures it on the first err_pulse after reset and holds it thereafter.
REQ-030 Without RS_MON_FIRST_FAIL_EN, first_fail_time SHALL be tied to 0 and the cycle counter omitted; all other behaviour is identical.

Structure
REQ-031 Package rs_mon_pkg SHALL hold the FSM state enum, the 2-bit input-code typedef and the default SETTLE_CYCLES and CNT_W constants.
REQ-032 Sub-module rs_sync2 (2-flop synchronizer, 1 bit, async active-low reset) SHALL be instantiated three times.

Verification
REQ-033 Reset, then notR=0 for 20 cycles with Q=0 -> check_count=1, error_count=0, pass=1.
REQ-034 notS=0 with Q held 0 -> err_pulse exactly 6 cycles after the notS fall at the default settle (2 synchronizer + 4 settle), error_count=1, pass=0.
REQ-035 notR=notS=0 -> one illegal_pulse, exp_valid=0, check_count unchanged; then notS=1 -> SETTLE, then CHECK with expected_q=0.
REQ-036 Toggle notS every 3 cycles with SETTLE_CYCLES=4 -> no comparisons while toggling; exactly one after toggling stops.
REQ-037 CNT_W=4 with 20 forced mismatches -> error_count stays at 15.
REQ-038 With RS_MON_FIRST_FAIL_EN, a mismatch at cycle 100 then another at cycle 200 -> first_fail_time=100 (±sync latency, fixed); without the macro -> 0.

Source files
------------

// File: rtl/rs_mon_pkg.sv
// -----------------------------------------------------------------------------
// rs_mon_pkg
// Shared types and constants for the RS latch monitor.
//   state_t  : monitor FSM states
//   code_t   : synchronized {notR, notS} input code
//   defaults : SETTLE_CYCLES_DEFAULT, CNT_W_DEFAULT
// -----------------------------------------------------------------------------
package rs_mon_pkg;

    localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT         = 16;

    // Cycles the synchronizers need after reset release before their outputs
    // reflect the real inputs.
    localparam logic [1:0] WARM_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Bit 1 = notR, bit 0 = notS
    typedef logic [1:0] code_t;

    localparam code_t CODE_ILLEGAL = 2'b00;
    localparam code_t CODE_RESET   = 2'b01;
    localparam code_t CODE_SET     = 2'b10;
    localparam code_t CODE_HOLD    = 2'b11;

    // True for codes that force the latch to a known value.
    function automatic logic is_drive_code(code_t c);
        return (c == CODE_SET) || (c == CODE_RESET);
    endfunction

endpackage

// File: rtl/rs_sync2.sv
// -----------------------------------------------------------------------------
// rs_sync2
// Two-flop synchronizer for one asynchronous bit.
//   clk_i   : sampling clock
//   rst_n_i : asynchronous active-low reset, clears both flops
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clock cycles of latency
// -----------------------------------------------------------------------------
module rs_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rs_latch_monitor.sv
// -----------------------------------------------------------------------------
// rs_latch_monitor
// Watches an external active-low RS latch, predicts its output from the
// synchronized notR/notS pair and compares it with the synchronized Q once the
// inputs have been stable for SETTLE_CYCLES.
//
// Parameters
//   SETTLE_CYCLES : stable cycles before a comparison (1..255)
//   CNT_W         : width of error_count / check_count
// Ports
//   Clock, nReset          : clock, asynchronous active-low reset
//   notR, notS, Q          : asynchronous signals of the observed latch
//   expected_q, exp_valid  : predicted Q and its validity
//   err_pulse              : one-cycle pulse per mismatch
//   illegal_pulse          : one-cycle pulse on entering notR=notS=0
//   error_count            : saturating mismatch count
//   check_count            : saturating comparison count
//   pass                   : comparisons made and none failed
//   first_fail_time        : cycle stamp of the first mismatch
// Build option
//   RS_MON_FIRST_FAIL_EN   : enables the free-running cycle counter feeding
//                            first_fail_time; otherwise the port reads 0.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_UNKNOWN | no valid prediction, nothing compared
// ST_SETTLE  | prediction valid, waiting for inputs to settle
// ST_CHECK   | comparison made on entry, idle until the next input change
// ST_ILLEGAL | notR=notS=0 seen, prediction invalid
// -----------------------------------------------------------------------------
module rs_latch_monitor
    import rs_mon_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             notR,
    input  logic             notS,
    input  logic             Q,
    output logic             expected_q,
    output logic             exp_valid,
    output logic             err_pulse,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] check_count,
    output logic             pass,
    output logic [31:0]      first_fail_time
);

    logic r_s, s_s, q_s;
    code_t code_s, code_q;
    logic  chg;

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       warm_q;
    logic             exp_q, exp_d;
    logic             expv_q, expv_d;
    logic             err_q, err_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;
    logic [CNT_W-1:0] chkcnt_q, chkcnt_d;
    logic             pass_q, pass_d;

    rs_sync2 u_sync_r (.clk_i(Clock), .rst_n_i(nReset), .d_i(notR), .q_o(r_s));
    rs_sync2 u_sync_s (.clk_i(Clock), .rst_n_i(nReset), .d_i(notS), .q_o(s_s));
    rs_sync2 u_sync_q (.clk_i(Clock), .rst_n_i(nReset), .d_i(Q),    .q_o(q_s));

    assign code_s = {r_s, s_s};
    assign chg    = (code_s != code_q);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        expv_d   = expv_q;
        err_d    = 1'b0;
        ill_d    = 1'b0;
        errcnt_d = errcnt_q;
        chkcnt_d = chkcnt_q;

        // Until the synchronizers have filled, their reset zeros would look
        // like an illegal code, so the FSM is held in UNKNOWN.
        if (warm_q == WARM_DONE) begin
            if (code_s == CODE_ILLEGAL) begin
                if (state_q != ST_ILLEGAL) begin
                    state_d = ST_ILLEGAL;
                    ill_d   = 1'b1;
                    exp_d   = 1'b0;
                    expv_d  = 1'b0;
                end
            end else if (chg) begin
                // An input change always wins over a comparison due this cycle.
                if (is_drive_code(code_s)) begin
                    state_d  = ST_SETTLE;
                    settle_d = 8'(SETTLE_CYCLES);
                    exp_d    = (code_s == CODE_SET);
                    expv_d   = 1'b1;
                end else if (expv_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = 8'(SETTLE_CYCLES);
                end else begin
                    // Hold after illegal/unknown: latch value is undefined.
                    state_d = ST_UNKNOWN;
                    exp_d   = 1'b0;
                    expv_d  = 1'b0;
                end
            end else begin
                case (state_q)
                    ST_UNKNOWN: begin
                        if (is_drive_code(code_s)) begin
                            state_d  = ST_SETTLE;
                            settle_d = 8'(SETTLE_CYCLES);
                            exp_d    = (code_s == CODE_SET);
                            expv_d   = 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        settle_d = settle_q - 8'd1;
                        if (settle_q == 8'd1) begin
                            state_d = ST_CHECK;
                            if (chkcnt_q != '1) chkcnt_d = chkcnt_q + CNT_W'(1);
                            if (q_s != exp_q) begin
                                err_d = 1'b1;
                                if (errcnt_q != '1) errcnt_d = errcnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        pass_d = (chkcnt_d != '0) && (errcnt_d == '0);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_UNKNOWN;
            settle_q <= '0;
            warm_q   <= '0;
            code_q   <= CODE_ILLEGAL;
            exp_q    <= 1'b0;
            expv_q   <= 1'b0;
            err_q    <= 1'b0;
            ill_q    <= 1'b0;
            errcnt_q <= '0;
            chkcnt_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            code_q   <= code_s;
            exp_q    <= exp_d;
            expv_q   <= expv_d;
            err_q    <= err_d;
            ill_q    <= ill_d;
            errcnt_q <= errcnt_d;
            chkcnt_q <= chkcnt_d;
            pass_q   <= pass_d;
            if (warm_q != WARM_DONE) warm_q <= warm_q + 2'd1;
        end
    end

`ifdef RS_MON_FIRST_FAIL_EN
    logic [31:0] cyc_q;
    logic [31:0] ffail_q;
    logic        ffail_seen_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cyc_q        <= '0;
            ffail_q      <= '0;
            ffail_seen_q <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (err_d && !ffail_seen_q) begin
                ffail_q      <= cyc_q;
                ffail_seen_q <= 1'b1;
            end
        end
    end

    assign first_fail_time = ffail_q;
`else
    assign first_fail_time = 32'd0;
`endif

    assign expected_q    = exp_q;
    assign exp_valid     = expv_q;
    assign err_pulse     = err_q;
    assign illegal_pulse = ill_q;
    assign error_count   = errcnt_q;
    assign check_count   = chkcnt_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_rs_latch_monitor.sv
// -----------------------------------------------------------------------------
// tb_rs_latch_monitor
// Directed bench for rs_latch_monitor. A behavioural model predicts every
// output from the observed input history; two DUT instances (CNT_W=16 and
// CNT_W=4) share the stimulus so counter saturation is exercised.
// -----------------------------------------------------------------------------
module tb_rs_latch_monitor;

    localparam int SETTLE = 4;

    logic Clock, nReset, notR, notS, Q;

    logic        expected_q, exp_valid, err_pulse, illegal_pulse, pass;
    logic [15:0] error_count, check_count;
    logic [31:0] first_fail_time;

    logic        d4_expected_q, d4_exp_valid, d4_err_pulse, d4_illegal_pulse, d4_pass;
    logic [3:0]  d4_error_count, d4_check_count;
    logic [31:0] d4_first_fail_time;

    rs_latch_monitor #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .Clock(Clock), .nReset(nReset), .notR(notR), .notS(notS), .Q(Q),
        .expected_q(expected_q), .exp_valid(exp_valid), .err_pulse(err_pulse),
        .illegal_pulse(illegal_pulse), .error_count(error_count),
        .check_count(check_count), .pass(pass), .first_fail_time(first_fail_time)
    );

    rs_latch_monitor #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut4 (
        .Clock(Clock), .nReset(nReset), .notR(notR), .notS(notS), .Q(Q),
        .expected_q(d4_expected_q), .exp_valid(d4_exp_valid), .err_pulse(d4_err_pulse),
        .illegal_pulse(d4_illegal_pulse), .error_count(d4_error_count),
        .check_count(d4_check_count), .pass(d4_pass), .first_fail_time(d4_first_fail_time)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The monitor sees each input sample two edges late; after a change of
    // the seen {notR,notS} pair it compares once, SETTLE edges later, if the
    // pair stayed put and the prediction is defined.
    typedef struct packed {logic r; logic s; logic q;} samp_t;
    samp_t      hist[$];
    int         n_edge, last_chg, n_chk, n_err, ff_time;
    bit         m_ev, m_valid, m_err, m_ill, m_ff_seen;
    logic [1:0] m_prev;

    task automatic model_reset();
        hist.delete();
        n_edge = 0; last_chg = 0; n_chk = 0; n_err = 0; ff_time = 0;
        m_ev = 0; m_valid = 0; m_err = 0; m_ill = 0; m_ff_seen = 0;
        m_prev = 2'b00;
    endtask

    task automatic model_step();
        samp_t      seen;
        logic [1:0] code;
        bit         changed;
        n_edge++;
        m_err = 0;
        m_ill = 0;
        hist.push_back(samp_t'({notR, notS, Q}));
        if (hist.size() > 3) void'(hist.pop_front());
        if (n_edge >= 3) begin
            seen    = hist[0];
            code    = {seen.r, seen.s};
            changed = (n_edge == 3) || (code != m_prev);
            m_prev  = code;
            if (changed) begin
                last_chg = n_edge;
                case (code)
                    2'b00:   begin m_valid = 0; m_ev = 0; m_ill = 1; end
                    2'b01:   begin m_valid = 1; m_ev = 0; end
                    2'b10:   begin m_valid = 1; m_ev = 1; end
                    default: ;
                endcase
            end else if (m_valid && n_edge == last_chg + SETTLE) begin
                n_chk++;
                if (seen.q != m_ev) begin
                    n_err++;
                    m_err = 1;
                    if (!m_ff_seen) begin
                        m_ff_seen = 1;
                        ff_time   = n_edge - 1;
                    end
                end
            end
        end
    endtask

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) model_reset();
        else         model_step();
    end

    function automatic longint sat(input int n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : longint'(n);
    endfunction

    always @(negedge Clock) begin
        longint exp_ff;
`ifdef RS_MON_FIRST_FAIL_EN
        exp_ff = ff_time;
`else
        exp_ff = 0;
`endif
        chk("expected_q",      expected_q,      m_ev);
        chk("exp_valid",       exp_valid,       m_valid);
        chk("err_pulse",       err_pulse,       m_err);
        chk("illegal_pulse",   illegal_pulse,   m_ill);
        chk("error_count",     error_count,     sat(n_err, 16));
        chk("check_count",     check_count,     sat(n_chk, 16));
        chk("pass",            pass,            (n_chk != 0) && (n_err == 0));
        chk("first_fail_time", first_fail_time, exp_ff);
        chk("w4_error_count",  d4_error_count,  sat(n_err, 4));
        chk("w4_check_count",  d4_check_count,  sat(n_chk, 4));
        chk("w4_pass",         d4_pass,         (n_chk != 0) && (n_err == 0));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic s, input logic q);
        @(posedge Clock);
        #3;
        notR = r; notS = s; Q = q;
    endtask

    task automatic settle_wait(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    int rise_k, ill_cnt, chk_before;

    initial begin
        nReset = 1'b0; notR = 1'b1; notS = 1'b1; Q = 1'b0;
        settle_wait(3);
        chk("rst_check_count", check_count, 0);
        chk("rst_exp_valid",   exp_valid,   0);
        chk("rst_pass",        pass,        0);
        chk("rst_first_fail",  first_fail_time, 0);

        // Reset asserted on notR with Q low: one passing comparison.
        @(posedge Clock); #3;
        nReset = 1'b1; notR = 1'b0; notS = 1'b1; Q = 1'b0;
        settle_wait(20);
        chk("s1_check_count", check_count, 1);
        chk("s1_error_count", error_count, 0);
        chk("s1_pass",        pass,        1);
        chk("s1_expected_q",  expected_q,  0);

        // Set with Q stuck low: err_pulse six edges after the first edge that
        // samples the change (2 sync + 4 settle), i.e. edge 7 from the drive.
        drive(1'b1, 1'b0, 1'b0);
        rise_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clock); #2;
            if (err_pulse && rise_k == 0) rise_k = k;
        end
        chk("s2_err_edge",    rise_k,      7);
        chk("s2_error_count", error_count, 1);
        chk("s2_pass",        pass,        0);

        // Hold with Q now high: prediction stays 1, comparison matches.
        drive(1'b1, 1'b1, 1'b1);
        settle_wait(12);
        chk("s3_check_count", check_count, 3);
        chk("s3_expected_q",  expected_q,  1);

        // Illegal code, then leave to reset code.
        chk_before = check_count;
        drive(1'b0, 1'b0, 1'b0);
        ill_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clock); #2;
            ill_cnt += int'(illegal_pulse);
        end
        chk("s4_illegal_pulses", ill_cnt,     1);
        chk("s4_exp_valid",      exp_valid,   0);
        chk("s4_check_same",     check_count, chk_before);
        drive(1'b0, 1'b1, 1'b0);
        settle_wait(12);
        chk("s4_expected_q",  expected_q,  0);
        chk("s4_exp_valid2",  exp_valid,   1);
        chk("s4_check_count", check_count, chk_before + 1);

        // Illegal then hold: prediction undefined again.
        drive(1'b0, 1'b0, 1'b0);
        settle_wait(5);
        drive(1'b1, 1'b1, 1'b0);
        settle_wait(12);
        chk("s4_hold_unknown", exp_valid, 0);

        // Toggle notS every 3 cycles: never settles.
        chk_before = check_count;
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (2) @(posedge Clock);
            drive(1'b1, ~notS, 1'b0);
        end
        #1;
        chk("s5_no_checks", check_count, chk_before);
        settle_wait(12);
        chk("s5_one_check", check_count, chk_before + 1);

        // 20 forced mismatches: prediction 1, Q 0.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            settle_wait(10);
        end
        chk("s6_w4_error_sat", d4_error_count, 15);
        chk("s6_w4_check_sat", d4_check_count, 15);

        // Reset in the middle of SETTLE: nothing counted.
        drive(1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge Clock);
        #3 nReset = 1'b0;
        settle_wait(2);
        chk("s7_rst_check", check_count, 0);
        chk("s7_rst_error", error_count, 0);
        @(posedge Clock); #3 nReset = 1'b1;
        settle_wait(12);
        chk("s7_check_count", check_count, 1);
        chk("s7_pass",        pass,        1);

        // First-fail stamp: mismatches compared at cycles 100 and 200.
        @(posedge Clock); #3;
        nReset = 1'b0; notR = 1'b1; notS = 1'b1; Q = 1'b0;
        repeat (2) @(posedge Clock);
        #3 nReset = 1'b1;
        repeat (93) @(posedge Clock);
        drive(1'b1, 1'b0, 1'b0);
        repeat (99) @(posedge Clock);
        drive(1'b1, 1'b1, 1'b0);
        settle_wait(12);
        chk("s8_error_count", error_count, 2);
`ifdef RS_MON_FIRST_FAIL_EN
        chk("s8_first_fail", first_fail_time, 100);
`else
        chk("s8_first_fail", first_fail_time, 0);
`endif

        settle_wait(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
